flit_mux_2to1: RTL and testbench
================================

// Module: flit_mux_2to1
// PURPOSE
//  - Two-input flit multiplexer for the NoC router datapath (characterization variant).
//  - Forwards one input port's flit (data, valid, VC id) to the single output port.
//  - The port is chosen by a one-hot select vector sized for the router's five ports.
//  - Outputs are registered; the output data bus holds while idle to minimise toggling.
// PARAMETERS
//  - DATA_W  18  flit data width in bits (idata_*/odata)
//  - VCH_W   2   virtual-channel id width in bits (ivch_*/ovch)
//  - SEL_W   5   select vector width (one bit per router port; bits [SEL_W-1:2] unused here)
// PORTS
//  - clk       in   1       single clock, all state on rising edge
//  - rst       in   1       synchronous reset, active-high
//  - idata_0   in   DATA_W  port-0 flit data
//  - ivalid_0  in   1       port-0 flit valid
//  - ivch_0    in   VCH_W   port-0 VC id
//  - idata_1   in   DATA_W  port-1 flit data
//  - ivalid_1  in   1       port-1 flit valid
//  - ivch_1    in   VCH_W   port-1 VC id
//  - sel       in   SEL_W   one-hot port select: 5'b00001 = port 0, 5'b00010 = port 1
//  - odata     out  DATA_W  selected flit data (registered)
//  - ovalid    out  1       selected flit valid (registered)
//  - ovch      out  VCH_W   selected VC id (registered)
//  - sel_err   out  1       illegal-select flag; present only with FLIT_MUX_SELCHK_EN
// BEHAVIOUR
//  - Reset: rst=1 at a clk edge -> odata=0, ovalid=0, ovch=0 (and sel_err=0) on the next cycle.
//  - Reset mid-packet discards the in-flight flit.
//  - Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
//  - Legal select values:
//      sel==1 -> port 0.
//      sel==2 -> port 1.
//  - Any other sel value (0, both bits set, or any bit in [SEL_W-1:2] set) -> no port selected.
//  - Port selected and its ivalid=1 at the edge:
//      odata <= idata_x; ovch <= ivch_x; ovalid <= 1.
//  - Port selected but its ivalid=0, or no port selected:
//      ovalid <= 0.
//      odata and ovch hold their previous values (no toggling while idle).
//  - No handshake or backpressure: every valid flit is forwarded, no buffering or drop.
//  - The non-selected port is ignored entirely, even if it is valid at the same time.
//  - sel may change on any cycle, including mid-packet; the new value takes effect at the next edge.
//  - Flit content, including the head/data/tail type bits, is passed through unmodified.
// CONFIGURATION
//  - FLIT_MUX_SELCHK_EN defined:
//      sel_err port exists.
//      sel_err <= 1 (registered, same cycle as the outputs) when sel is not 1 or 2, else 0.
//      Reset value is 0.
//  - FLIT_MUX_SELCHK_EN undefined:
//      sel_err port and its logic are absent.
//      All other behaviour is identical.
// TESTING
//  - Reset: hold rst=1 for 2 cycles with random inputs -> odata=0, ovalid=0, ovch=0.
//  - Port 1 forwarding:
//      stimulus: sel=5'b00010, ivalid_1=1, ivch_1=2'd1, idata_1=18'h3C000;
//                port 0 valid with 18'h00009 at the same time.
//      response: one cycle later odata=18'h3C000, ovalid=1, ovch=1.
//  - Port 0 forwarding: sel=5'b00001, ivalid_0=1, idata_0=18'h00009, ivch_0=2 -> next cycle odata=18'h00009, ovch=2, ovalid=1.
//  - Idle hold: after the port-1 flit 18'h0000F, drop ivalid_1 to 0 -> ovalid=0 and odata stays 18'h0000F.
//  - Illegal select:
//      stimulus: sel=5'b00011, then sel=5'b00000, with both ports valid.
//      response: ovalid=0 and odata holds; sel_err=1 when FLIT_MUX_SELCHK_EN is defined.
//  - Packet stream:
//      stimulus: port 1 selected; 10 packets of head + 20 data + tail flits, 7 idle cycles between packets.
//      response: every valid flit appears on odata in order, 1 cycle late; no loss or duplication.

Source files
------------

// File: rtl/flit_mux_2to1.sv
// Two-input NoC flit multiplexer with one-hot port select and registered outputs.
// Optional illegal-select flag output enabled by defining FLIT_MUX_SELCHK_EN.
module flit_mux_2to1 #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned VCH_W  = 2,
  parameter int unsigned SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
`ifdef FLIT_MUX_SELCHK_EN
  ,
  output logic              sel_err
`endif
);

  localparam logic [SEL_W-1:0] SEL_PORT0 = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_PORT1 = SEL_W'(2);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [VCH_W-1:0]  vch;
  } flit_t;

  logic  pick_0;
  logic  pick_1;
  logic  fwd_valid;
  flit_t fwd_flit;

  // Decode the select and steer the chosen port's flit; anything but an exact match idles.
  always_comb begin
    pick_0    = 1'b0;
    pick_1    = 1'b0;
    fwd_valid = 1'b0;
    fwd_flit  = '0;
    if (sel == SEL_PORT0) begin
      pick_0 = 1'b1;
    end else if (sel == SEL_PORT1) begin
      pick_1 = 1'b1;
    end
    if (pick_0) begin
      fwd_valid = ivalid_0;
      fwd_flit  = '{data: idata_0, vch: ivch_0};
    end else if (pick_1) begin
      fwd_valid = ivalid_1;
      fwd_flit  = '{data: idata_1, vch: ivch_1};
    end
  end

  // Output register; payload only loads on a forwarded flit so the bus stays quiet when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      odata  <= '0;
      ovch   <= '0;
    end else begin
      ovalid <= fwd_valid;
      if (fwd_valid) begin
        odata <= fwd_flit.data;
        ovch  <= fwd_flit.vch;
      end
    end
  end

`ifdef FLIT_MUX_SELCHK_EN
  // Flag any select that is not exactly one of the two legal one-hot codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= ~(pick_0 | pick_1);
    end
  end
`endif

endmodule

// File: tb/tb_flit_mux_2to1.sv
// Randomized scoreboard bench for flit_mux_2to1; checks sel_err when FLIT_MUX_SELCHK_EN is defined.
module tb_flit_mux_2to1;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned VCH_W  = 2;
  localparam int unsigned SEL_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] idata_0 = '0;
  logic              ivalid_0 = 1'b0;
  logic [VCH_W-1:0]  ivch_0 = '0;
  logic [DATA_W-1:0] idata_1 = '0;
  logic              ivalid_1 = 1'b0;
  logic [VCH_W-1:0]  ivch_1 = '0;
  logic [SEL_W-1:0]  sel = '0;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;
  logic              sel_err_w;

  flit_mux_2to1 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
`ifdef FLIT_MUX_SELCHK_EN
    ,
    .sel_err  (sel_err_w)
`endif
  );

`ifndef FLIT_MUX_SELCHK_EN
  assign sel_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [VCH_W-1:0]  c;
    logic              e;
    int                ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   stream_flits = 0;

  // Reference state: last forwarded payload, which the output holds between flits.
  logic [DATA_W-1:0] m_data = '0;
  logic [VCH_W-1:0]  m_vch  = '0;

  function automatic string ph_name(input int ph);
    case (ph)
      0: return "reset";
      1: return "port1_fwd";
      2: return "port0_fwd";
      3: return "idle_hold";
      4: return "illegal_sel";
      5: return "midpkt_reset";
      6: return "pkt_stream";
      default: return "random";
    endcase
  endfunction

  task automatic drive(input logic r, input logic [SEL_W-1:0] s,
                       input logic v0, input logic [DATA_W-1:0] d0, input logic [VCH_W-1:0] c0,
                       input logic v1, input logic [DATA_W-1:0] d1, input logic [VCH_W-1:0] c1,
                       input int ph);
    exp_t e;
    logic legal;
    @(negedge clk);
    rst = r; sel = s;
    ivalid_0 = v0; idata_0 = d0; ivch_0 = c0;
    ivalid_1 = v1; idata_1 = d1; ivch_1 = c1;
    legal = ($countones(s) == 1) && (s[SEL_W-1:2] == '0);
    e.ph = ph;
    if (r) begin
      m_data = '0; m_vch = '0;
      e.v = 1'b0; e.e = 1'b0;
    end else begin
      e.e = ~legal;
      e.v = 1'b0;
      if (legal && s[1] && v1) begin
        e.v = 1'b1; m_data = d1; m_vch = c1;
      end else if (legal && s[0] && v0) begin
        e.v = 1'b1; m_data = d0; m_vch = c0;
      end
    end
    e.d = m_data;
    e.c = m_vch;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a result; compare it against the oldest expectation.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        ok = (ovalid === e.v) && (odata === e.d) && (ovch === e.c);
`ifdef FLIT_MUX_SELCHK_EN
        ok = ok && (sel_err_w === e.e);
`endif
        if (e.ph == 6 && ovalid === 1'b1) stream_flits++;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got v=%b d=%h vc=%h err=%b, expected v=%b d=%h vc=%h err=%b",
                   ph_name(e.ph), ovalid, odata, ovch, sel_err_w, e.v, e.d, e.c, e.e);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rdata();
    return DATA_W'($urandom);
  endfunction

  function automatic logic [SEL_W-1:0] rsel();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return SEL_W'(1);
    if (r < 8) return SEL_W'(2);
    if (r == 8) return SEL_W'($urandom);
    return ($urandom_range(0, 1) == 1) ? SEL_W'(3) : SEL_W'(0);
  endfunction

  initial begin
    logic [DATA_W-1:0] fd;
    // Reset with random inputs
    repeat (2) drive(1'b1, rsel(), 1'b1, rdata(), VCH_W'($urandom), 1'b1, rdata(), VCH_W'($urandom), 0);

    drive(1'b0, 5'b00010, 1'b1, 18'h00009, 2'd0, 1'b1, 18'h3C000, 2'd1, 1);
    drive(1'b0, 5'b00001, 1'b1, 18'h00009, 2'd2, 1'b0, 18'h12345, 2'd3, 2);

    drive(1'b0, 5'b00010, 1'b0, rdata(), 2'd0, 1'b1, 18'h0000F, 2'd3, 3);
    drive(1'b0, 5'b00010, 1'b1, rdata(), 2'd1, 1'b0, rdata(), 2'd2, 3);
    drive(1'b0, 5'b00010, 1'b0, rdata(), 2'd1, 1'b0, rdata(), 2'd0, 3);

    drive(1'b0, 5'b00011, 1'b1, rdata(), 2'd1, 1'b1, rdata(), 2'd2, 4);
    drive(1'b0, 5'b00000, 1'b1, rdata(), 2'd1, 1'b1, rdata(), 2'd2, 4);
    drive(1'b0, 5'b00101, 1'b1, rdata(), 2'd1, 1'b1, rdata(), 2'd2, 4);
    drive(1'b0, 5'b10000, 1'b1, rdata(), 2'd1, 1'b1, rdata(), 2'd2, 4);

    drive(1'b0, 5'b00010, 1'b0, rdata(), 2'd0, 1'b1, {2'b10, 16'hBEEF}, 2'd1, 5);
    drive(1'b1, 5'b00010, 1'b0, rdata(), 2'd0, 1'b1, {2'b00, 16'h1234}, 2'd1, 5);
    drive(1'b0, 5'b00010, 1'b0, rdata(), 2'd0, 1'b0, rdata(), 2'd1, 5);

    // Packets on port 1: head, 20 body, tail, then 7 idle cycles; port 0 carries noise
    for (int p = 0; p < 10; p++) begin
      for (int f = 0; f < 22; f++) begin
        fd = {(f == 0) ? 2'b10 : (f == 21) ? 2'b01 : 2'b00, 16'($urandom)};
        drive(1'b0, 5'b00010, 1'($urandom), rdata(), VCH_W'($urandom), 1'b1, fd, VCH_W'(p), 6);
      end
      repeat (7) drive(1'b0, 5'b00010, 1'($urandom), rdata(), VCH_W'($urandom), 1'b0, rdata(), VCH_W'($urandom), 6);
    end

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), rsel(), 1'($urandom), rdata(), VCH_W'($urandom),
            1'($urandom), rdata(), VCH_W'($urandom), 7);
    end

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (stream_flits != 220) begin
      n_fail++;
      $display("FAIL stream_count: got %0d flits, expected 220", stream_flits);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
